imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Boot sequencer for the single-cycle RISC-V core.
- Holds the core in reset, streams program words from an external valid/ready source into instruction memory, then releases the core.
- Sits between the testbench/host loader interface and Single_cycle_top: drives the instruction-memory write port and the core's active-low reset.
- A later load_req re-halts the core and reloads memory.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2^ADDR_W words.
- HOLD_CYC, 4, cycles core reset stays asserted after the last write before release; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_req  in  1  single-cycle start/restart request.
- ld_valid  in  1  source has a word.
- ld_data  in  32  program word.
- ld_last  in  1  qualifies the final program word (valid only with ld_valid).
- ld_ready  out  1  loader accepts a word this cycle.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  write data.
- core_rst  out  1  active-low reset to the core; 0 = core held.
- busy  out  1  high in LOAD, CSUM and HOLD.
- done  out  1  high in RUN.
- err  out  1  high in ERR.
- word_cnt  out  ADDR_W+1  words written in current/last load.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, including core_rst=0 (core held); internal sum and hold counter 0.
- IDLE:
  - ld_ready=0, core_rst=0.
  - load_req=1 -> LOAD; word_cnt and sum cleared on the same edge.
- LOAD:
  - ld_ready=1; a word is accepted on any edge with ld_valid & ld_ready.
  - Accepted word is registered: imem_we=1 for exactly one cycle, the cycle after acceptance, with imem_addr = word_cnt value at acceptance (low ADDR_W bits) and imem_wdata = ld_data. word_cnt increments on the acceptance edge.
  - imem_we=0 in every cycle not following an acceptance. Back-to-back acceptances give back-to-back writes; throughput is 1 word/cycle.
  - Accepted ld_last -> HOLD; with LOADER_CSUM_EN defined -> CSUM instead.
  - Overflow: a word accepted while word_cnt == DEPTH -> ERR. No write is issued and word_cnt does not change.
  - ld_valid=0 stalls indefinitely; there is no timeout.
- HOLD:
  - ld_ready=0, core_rst=0; hold counter counts HOLD_CYC cycles from HOLD entry. The final write from the last word lands in the first HOLD cycle.
  - On expiry -> RUN.
- RUN:
  - core_rst=1, done=1.
  - load_req=1 -> LOAD. core_rst falls to 0 on that same edge; done=0, word_cnt cleared.
- ERR:
  - core_rst=0, err=1, ld_ready=0.
  - load_req -> LOAD, clearing err.
- load_req is ignored in LOAD, CSUM and HOLD.
- Async reset mid-load aborts immediately. Partial memory contents are left as written; core stays held.

Optional Feature:
- Macro LOADER_CSUM_EN.
- Defined:
  - Running sum = 32-bit wrap-around sum (mod 2^32) of all accepted data words.
  - CSUM state has ld_ready=1 and accepts exactly one further word, which is not written to memory.
  - Equal to sum -> HOLD; otherwise -> ERR. ld_last on this word is ignored.
- Not defined: no sum register and no CSUM state; last data word goes directly to HOLD.

Decomposition:
- Package loader_pkg holds:
  - state enum: IDLE, LOAD, CSUM, HOLD, RUN, ERR;
  - LD_DATA_W=32;
  - default HOLD_CYC.
- Flat module; no sub-module is natural. Hold counter and FSM are small enough to stay inline.

Test Plan:
- rst low then high; no load_req for 10 cycles -> core_rst=0, ld_ready=0, all other outputs 0.
- load_req; 3 words 0x00500093, 0x00A00113, 0x002081B3, last on 3rd, continuous valid -> imem_we pulses at addr 0,1,2 on consecutive cycles; core_rst=1 exactly HOLD_CYC=4 cycles after last write; done=1; word_cnt=3.
- Same stream with ld_valid gapped every other cycle -> same addresses/data, writes spaced 2 cycles apart, release timing relative to last write unchanged.
- ADDR_W=2: 5 words with no ld_last -> 4 writes at addr 0..3, 5th word causes err=1, no 5th write, core_rst=0; then load_req -> err=0, LOAD.
- In RUN, pulse load_req -> core_rst drops on that same edge; reload of 1 word (last) writes addr 0 and releases again.
- LOADER_CSUM_EN: words 1, 2, 0xFFFFFFFF then checksum 0x00000002 -> RUN; repeat with checksum 0x00000003 -> ERR, core_rst=0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and defaults for the instruction-memory boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package loader_pkg;

    localparam int LD_DATA_W    = 32;
    localparam int ADDR_W_DEF   = 8;
    localparam int HOLD_CYC_DEF = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CSUM = 3'd2,
        HOLD = 3'd3,
        RUN  = 3'd4,
        ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot sequencer: holds the core in reset, streams words into imem, then releases it (LOADER_CSUM_EN adds a trailing checksum word).
// Latency: write issued the cycle after acceptance; core_rst rises HOLD_CYC cycles after HOLD entry.
// Backpressure: ld_ready high only in LOAD/CSUM; source stalls freely with ld_valid=0.
module imem_boot_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_req,
    input  logic                 ld_valid,
    input  logic [LD_DATA_W-1:0] ld_data,
    input  logic                 ld_last,
    output logic                 ld_ready,
    output logic                 imem_we,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic [LD_DATA_W-1:0] imem_wdata,
    output logic                 core_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_W:0]      word_cnt
);

    localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [7:0]      HOLD_LAST = 8'(HOLD_CYC - 1);

    state_t                 state_q, state_d;
    logic [ADDR_W:0]        cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [LD_DATA_W-1:0]   wdata_q, wdata_d;
    logic [7:0]             hold_q, hold_d;
`ifdef LOADER_CSUM_EN
    logic [LD_DATA_W-1:0]   sum_q, sum_d;
`endif

    logic accept;
    logic full;
    logic start;

    assign accept = ld_valid & ld_ready;
    assign full   = (cnt_q == DEPTH);
    assign start  = load_req & ((state_q == IDLE) | (state_q == RUN) | (state_q == ERR));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RUN, ERR: begin
                if (load_req) state_d = LOAD;
            end
            LOAD: begin
                if (accept) begin
                    // A word arriving with memory already full wins over ld_last.
                    if (full) begin
                        state_d = ERR;
                    end else if (ld_last) begin
`ifdef LOADER_CSUM_EN
                        state_d = CSUM;
`else
                        state_d = HOLD;
`endif
                    end
                end
            end
`ifdef LOADER_CSUM_EN
            CSUM: begin
                if (accept) state_d = (ld_data == sum_q) ? HOLD : ERR;
            end
`endif
            HOLD: begin
                if (hold_q == HOLD_LAST) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ld_ready = (state_q == LOAD) | (state_q == CSUM);
        core_rst = (state_q == RUN);
        busy     = (state_q == LOAD) | (state_q == CSUM) | (state_q == HOLD);
        done     = (state_q == RUN);
        err      = (state_q == ERR);
    end

    always_comb begin
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef LOADER_CSUM_EN
        sum_d   = sum_q;
`endif
        if (start) begin
            cnt_d = '0;
`ifdef LOADER_CSUM_EN
            sum_d = '0;
`endif
        end
        if ((state_q == LOAD) && accept && !full) begin
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            wdata_d = ld_data;
            cnt_d   = cnt_q + 1'b1;
`ifdef LOADER_CSUM_EN
            sum_d   = sum_q + ld_data;
`endif
        end
        // Counter sits at zero outside HOLD so every HOLD entry starts fresh.
        hold_d = ((state_q == HOLD) && (state_d == HOLD)) ? hold_q + 8'd1 : 8'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= '0;
`ifdef LOADER_CSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
`ifdef LOADER_CSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader (small 4-word memory, HOLD_CYC=4).
module tb_imem_boot_loader;

    localparam int AW    = 2;
    localparam int HC    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_req;
    logic          ld_valid;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_cnt;

    int total = 0;
    int bad   = 0;
    logic [31:0] prog[$];

    imem_boot_loader #(.ADDR_W(AW), .HOLD_CYC(HC)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_core_rst"}, core_rst, 0);
        chk({tag, "_ld_ready"}, ld_ready, 0);
        chk({tag, "_imem_we"},  imem_we, 0);
        chk({tag, "_addr"},     imem_addr, 0);
        chk({tag, "_wdata"},    imem_wdata, 0);
        chk({tag, "_busy"},     busy, 0);
        chk({tag, "_done"},     done, 0);
        chk({tag, "_err"},      err, 0);
        chk({tag, "_word_cnt"}, word_cnt, 0);
    endtask

    task automatic start_load();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ready", ld_ready, 1);
        chk("start_core_rst", core_rst, 0);
        chk("start_done", done, 0);
        chk("start_err", err, 0);
        chk("start_cnt", word_cnt, 0);
    endtask

    // Idle gap cycles (no write expected), then one accepted word.
    task automatic send_word(input logic [31:0] d, input bit last, input int gap, input bit stray);
        ld_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            load_req = stray;
            step();
            load_req = 1'b0;
            chk("gap_no_write", imem_we, 0);
            chk("gap_ready", ld_ready, 1);
        end
        chk("pre_ready", ld_ready, 1);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        load_req = stray;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        load_req = 1'b0;
    endtask

    // Called in the first HOLD cycle; release must come HC cycles later.
    task automatic wait_release(input int n);
        int k;
        chk("hold_busy", busy, 1);
        chk("hold_ready", ld_ready, 0);
        chk("hold_core_rst", core_rst, 0);
        k = 0;
        while (core_rst !== 1'b1 && k < 20) begin
            load_req = 1'($urandom_range(1, 0));
            ld_valid = 1'($urandom_range(1, 0));
            ld_data  = $urandom;
            step();
            load_req = 1'b0;
            ld_valid = 1'b0;
            k++;
            if (core_rst !== 1'b1) chk("hold_quiet", {imem_we, ld_ready, busy}, 3'b001);
        end
        chk("release_delay", k, HC);
        chk("run_done", done, 1);
        chk("run_busy", busy, 0);
        chk("run_err", err, 0);
        chk("run_ready", ld_ready, 0);
        chk("run_cnt", word_cnt, n);
    endtask

    task automatic run_load(input int n, input int gmin, input int gmax, input bit stray,
                            input logic [31:0] cs_delta);
        logic [31:0] sum;
        logic [31:0] d;
        sum = 32'd0;
        start_load();
        for (int i = 0; i < n; i++) begin
            d = prog[i];
            send_word(d, i == n - 1, $urandom_range(gmax, gmin), stray);
            chk("wr_we", imem_we, 1);
            chk("wr_addr", imem_addr, i);
            chk("wr_data", imem_wdata, d);
            chk("wr_cnt", word_cnt, i + 1);
            sum = sum + d;
        end
`ifdef LOADER_CSUM_EN
        chk("csum_ready", ld_ready, 1);
        chk("csum_busy", busy, 1);
        chk("csum_core_rst", core_rst, 0);
        ld_valid = 1'b1;
        ld_data  = sum + cs_delta;
        ld_last  = 1'($urandom_range(1, 0));
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("csum_no_write", imem_we, 0);
        chk("csum_cnt", word_cnt, n);
        if (cs_delta == 32'd0) begin
            wait_release(n);
        end else begin
            chk("csum_err", err, 1);
            chk("csum_err_core_rst", core_rst, 0);
            chk("csum_err_ready", ld_ready, 0);
            chk("csum_err_busy", busy, 0);
            chk("csum_err_done", done, 0);
        end
`else
        chk("nocsum_delta_zero", cs_delta, 0);
        wait_release(n);
`endif
    endtask

    task automatic run_overflow();
        logic [31:0] d;
        start_load();
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            send_word(d, 1'b0, $urandom_range(1, 0), 1'b0);
            chk("ovf_wr_we", imem_we, 1);
            chk("ovf_wr_addr", imem_addr, i);
            chk("ovf_wr_data", imem_wdata, d);
        end
        send_word($urandom, 1'b0, 0, 1'b0);
        chk("ovf_no_write", imem_we, 0);
        chk("ovf_err", err, 1);
        chk("ovf_cnt", word_cnt, DEPTH);
        chk("ovf_core_rst", core_rst, 0);
        chk("ovf_ready", ld_ready, 0);
        chk("ovf_busy", busy, 0);
        step();
        chk("ovf_err_sticky", err, 1);
    endtask

    initial begin
        rst      = 1'b0;
        load_req = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 32'd0;
        ld_last  = 1'b0;
        repeat (3) step();
        chk_all_zero("in_reset");
        rst = 1'b1;
        repeat (10) step();
        chk_all_zero("idle");

        // Example program, continuous valid.
        prog = '{32'h00500093, 32'h00A00113, 32'h002081B3};
        run_load(3, 0, 0, 1'b0, 32'd0);

        // Same program with ld_valid gapped every other cycle, restarted from RUN.
        run_load(3, 1, 1, 1'b0, 32'd0);

        // Overflow, then recovery from ERR with a single-word load.
        run_overflow();
        prog = '{32'hDEADBEEF};
        run_load(1, 0, 0, 1'b0, 32'd0);
        prog = '{32'h12345678};
        run_load(1, 0, 0, 1'b0, 32'd0);

`ifdef LOADER_CSUM_EN
        prog = '{32'h00000001, 32'h00000002, 32'hFFFFFFFF};
        run_load(3, 0, 0, 1'b0, 32'd0);
        run_load(3, 0, 0, 1'b0, 32'd1);
        prog = '{32'h00000005};
        run_load(1, 0, 0, 1'b0, 32'd0);
`endif

        // Async reset in the middle of a load.
        start_load();
        send_word(32'hCAFEF00D, 1'b0, 0, 1'b0);
        send_word(32'h0BADC0DE, 1'b0, 0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk_all_zero("midload_rst");
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("post_rst_ready", ld_ready, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_core_rst", core_rst, 0);

        // Randomized loads with stray load_req, random gaps and occasional overflow.
        for (int t = 0; t < 25; t++) begin
            int n;
            logic [31:0] delta;
            if ($urandom_range(5, 0) == 0) begin
                run_overflow();
            end else begin
                n = $urandom_range(DEPTH, 1);
                prog.delete();
                for (int i = 0; i < n; i++) prog.push_back($urandom);
`ifdef LOADER_CSUM_EN
                delta = ($urandom_range(1, 0) == 0) ? 32'd0 : 32'($urandom_range(1000, 1));
`else
                delta = 32'd0;
`endif
                run_load(n, 0, 2, 1'($urandom_range(1, 0)), delta);
            end
            repeat ($urandom_range(3, 0)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
